pipe_maindec: RTL and testbench

PIPE_MAINDEC -- requirements
Module: pipe_maindec

---
 rtl/pipe_maindec_if.sv | 65 ++++++
 rtl/pipe_maindec.sv | 245 ++++++++++++++++++++++++
 tb/tb_pipe_maindec.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_maindec_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_maindec_if
// Description : Decode-stage inputs and pipelined control outputs of the
//               main decoder, grouped as one bundle. The master side drives
//               the opcode and pipeline qualifiers; the slave side (the
//               decoder) drives the per-stage controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_maindec_if #(
   parameter int CNT_W = 8
);
   // Decode-stage qualifiers
   logic [6:0]       op_d;
   logic             valid_d;
   logic             stall_d;
   logic             flush_e;

   // Combinational immediate select
   logic [2:0]       ImmSrcD;

   // Execute-stage controls
   logic             RegWriteE;
   logic             MemWriteE;
   logic             BranchE;
   logic             JumpE;
   logic             JalrE;
   logic             ALUSrcE;
   logic             IllegalE;
   logic [1:0]       ResultSrcE;
   logic [1:0]       ALUOpE;

   // Memory-stage controls
   logic             RegWriteM;
   logic             MemWriteM;
   logic [1:0]       ResultSrcM;

   // Writeback-stage controls
   logic             RegWriteW;
   logic [1:0]       ResultSrcW;

   // Saturating count of illegal opcodes that entered Execute
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output op_d, valid_d, stall_d, flush_e,
      input  ImmSrcD,
      input  RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, IllegalE,
      input  ResultSrcE, ALUOpE,
      input  RegWriteM, MemWriteM, ResultSrcM,
      input  RegWriteW, ResultSrcW,
      input  illegal_cnt
   );

   modport slave (
      input  op_d, valid_d, stall_d, flush_e,
      output ImmSrcD,
      output RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, IllegalE,
      output ResultSrcE, ALUOpE,
      output RegWriteM, MemWriteM, ResultSrcM,
      output RegWriteW, ResultSrcW,
      output illegal_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipe_maindec.sv
`default_nettype none
// ============================================================================
// Module      : pipe_maindec
// Description : RISC-V main decoder with the control pipeline D->E->M->W.
//               The opcode is decoded combinationally in Decode; the controls
//               are registered into Execute (bubbled on stall/flush), then
//               advance unconditionally to Memory and Writeback. Illegal
//               opcodes reaching Execute are flagged and counted with a
//               saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_maindec #(
   parameter int EXT_OPS = 1,
   parameter int CNT_W   = 8
) (
   input  wire logic       clk,
   input  wire logic       reset,
   pipe_maindec_if.slave   bus
);

   // ------------------------------------------------------------------------
   // Opcodes
   // ------------------------------------------------------------------------
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_IALU   = 7'b0010011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;

   // Immediate select encodings
   localparam logic [2:0] c_IMM_I = 3'b000;
   localparam logic [2:0] c_IMM_S = 3'b001;
   localparam logic [2:0] c_IMM_B = 3'b010;
   localparam logic [2:0] c_IMM_J = 3'b011;
   localparam logic [2:0] c_IMM_U = 3'b100;

   // Result select encodings
   localparam logic [1:0] c_RES_ALU = 2'b00;
   localparam logic [1:0] c_RES_MEM = 2'b01;
   localparam logic [1:0] c_RES_PC4 = 2'b10;
   localparam logic [1:0] c_RES_IMM = 2'b11;

   // ALU operation classes
   localparam logic [1:0] c_ALU_ADD  = 2'b00;
   localparam logic [1:0] c_ALU_SUB  = 2'b01;
   localparam logic [1:0] c_ALU_FUNC = 2'b10;

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

   // Decoded control word, field order follows the decode table
   typedef struct packed {
      logic       regWrite;
      logic [2:0] immSrc;
      logic       aluSrc;
      logic       memWrite;
      logic [1:0] resultSrc;
      logic       branch;
      logic [1:0] aluOp;
      logic       jump;
      logic       jalr;
   } ctrl_t;

   // ------------------------------------------------------------------------
   // Extension enable (JALR / LUI)
   // ------------------------------------------------------------------------
   logic w_extEn;

   generate
      if (EXT_OPS != 0) begin : g_extOn
         assign w_extEn = 1'b1;
      end else begin : g_extOff
         assign w_extEn = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Decode stage
   // ------------------------------------------------------------------------
   ctrl_t w_dec;
   logic  w_illegal;
   logic  w_bubble;
   logic  w_loadIllegal;

   // Opcode decode; unknown opcodes produce an all-zero word plus the illegal flag
   always_comb begin
      w_dec     = '0;
      w_illegal = 1'b0;
      if (bus.valid_d) begin
         case (bus.op_d)
            c_OP_LOAD:   w_dec = {1'b1, c_IMM_I, 1'b1, 1'b0, c_RES_MEM,
                                  1'b0, c_ALU_ADD, 1'b0, 1'b0};
            c_OP_STORE:  w_dec = {1'b0, c_IMM_S, 1'b1, 1'b1, c_RES_ALU,
                                  1'b0, c_ALU_ADD, 1'b0, 1'b0};
            c_OP_RTYPE:  w_dec = {1'b1, c_IMM_I, 1'b0, 1'b0, c_RES_ALU,
                                  1'b0, c_ALU_FUNC, 1'b0, 1'b0};
            c_OP_BRANCH: w_dec = {1'b0, c_IMM_B, 1'b0, 1'b0, c_RES_ALU,
                                  1'b1, c_ALU_SUB, 1'b0, 1'b0};
            c_OP_IALU:   w_dec = {1'b1, c_IMM_I, 1'b1, 1'b0, c_RES_ALU,
                                  1'b0, c_ALU_FUNC, 1'b0, 1'b0};
            c_OP_JAL:    w_dec = {1'b1, c_IMM_J, 1'b0, 1'b0, c_RES_PC4,
                                  1'b0, c_ALU_ADD, 1'b1, 1'b0};
            c_OP_JALR: begin
               if (w_extEn) begin
                  w_dec = {1'b1, c_IMM_I, 1'b1, 1'b0, c_RES_PC4,
                           1'b0, c_ALU_ADD, 1'b1, 1'b1};
               end else begin
                  w_illegal = 1'b1;
               end
            end
            c_OP_LUI: begin
               if (w_extEn) begin
                  w_dec = {1'b1, c_IMM_U, 1'b0, 1'b0, c_RES_IMM,
                           1'b0, c_ALU_ADD, 1'b0, 1'b0};
               end else begin
                  w_illegal = 1'b1;
               end
            end
            default:     w_illegal = 1'b1;
         endcase
      end
   end

   // Immediate select is consumed in Decode, so it bypasses the bubble logic
   assign bus.ImmSrcD = w_dec.immSrc;

   // A flush or a stall both turn the D->E transfer into a single bubble
   assign w_bubble      = bus.flush_e | bus.stall_d;
   assign w_loadIllegal = w_illegal & ~w_bubble;

   // ------------------------------------------------------------------------
   // Execute-stage register
   // ------------------------------------------------------------------------
   logic       r_regWriteE;
   logic       r_memWriteE;
   logic       r_branchE;
   logic       r_jumpE;
   logic       r_jalrE;
   logic       r_aluSrcE;
   logic       r_illegalE;
   logic [1:0] r_resultSrcE;
   logic [1:0] r_aluOpE;

   // D->E transfer: reset clears, flush/stall inserts a bubble, else load decode
   always_ff @(posedge clk) begin
      if (reset || w_bubble) begin
         r_regWriteE  <= 1'b0;
         r_memWriteE  <= 1'b0;
         r_branchE    <= 1'b0;
         r_jumpE      <= 1'b0;
         r_jalrE      <= 1'b0;
         r_aluSrcE    <= 1'b0;
         r_illegalE   <= 1'b0;
         r_resultSrcE <= 2'b00;
         r_aluOpE     <= 2'b00;
      end else begin
         // An illegal opcode must never write state, whatever the table says
         r_regWriteE  <= w_dec.regWrite & ~w_illegal;
         r_memWriteE  <= w_dec.memWrite & ~w_illegal;
         r_branchE    <= w_dec.branch;
         r_jumpE      <= w_dec.jump;
         r_jalrE      <= w_dec.jalr;
         r_aluSrcE    <= w_dec.aluSrc;
         r_illegalE   <= w_illegal;
         r_resultSrcE <= w_dec.resultSrc;
         r_aluOpE     <= w_dec.aluOp;
      end
   end

   // ------------------------------------------------------------------------
   // Memory-stage register
   // ------------------------------------------------------------------------
   logic       r_regWriteM;
   logic       r_memWriteM;
   logic [1:0] r_resultSrcM;

   // E->M advances every cycle; the illegal flag stops at Execute
   always_ff @(posedge clk) begin
      if (reset) begin
         r_regWriteM  <= 1'b0;
         r_memWriteM  <= 1'b0;
         r_resultSrcM <= 2'b00;
      end else begin
         r_regWriteM  <= r_regWriteE;
         r_memWriteM  <= r_memWriteE;
         r_resultSrcM <= r_resultSrcE;
      end
   end

   // ------------------------------------------------------------------------
   // Writeback-stage register
   // ------------------------------------------------------------------------
   logic       r_regWriteW;
   logic [1:0] r_resultSrcW;

   // M->W advances every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_regWriteW  <= 1'b0;
         r_resultSrcW <= 2'b00;
      end else begin
         r_regWriteW  <= r_regWriteM;
         r_resultSrcW <= r_resultSrcM;
      end
   end

   // ------------------------------------------------------------------------
   // Illegal-opcode counter
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] r_illegalCnt;

   // Counts on the same edge that raises IllegalE, so the count always
   // includes the instruction currently flagged in Execute; holds at max.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_illegalCnt <= '0;
      end else if (w_loadIllegal && (r_illegalCnt != c_CNT_MAX)) begin
         r_illegalCnt <= r_illegalCnt + c_CNT_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.RegWriteE   = r_regWriteE;
   assign bus.MemWriteE   = r_memWriteE;
   assign bus.BranchE     = r_branchE;
   assign bus.JumpE       = r_jumpE;
   assign bus.JalrE       = r_jalrE;
   assign bus.ALUSrcE     = r_aluSrcE;
   assign bus.IllegalE    = r_illegalE;
   assign bus.ResultSrcE  = r_resultSrcE;
   assign bus.ALUOpE      = r_aluOpE;
   assign bus.RegWriteM   = r_regWriteM;
   assign bus.MemWriteM   = r_memWriteM;
   assign bus.ResultSrcM  = r_resultSrcM;
   assign bus.RegWriteW   = r_regWriteW;
   assign bus.ResultSrcW  = r_resultSrcW;
   assign bus.illegal_cnt = r_illegalCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_maindec.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_maindec
// Description : Self-checking bench for pipe_maindec. Two instances run side
//               by side on identical stimulus: A with EXT_OPS=1/CNT_W=8 and
//               B with EXT_OPS=0/CNT_W=2. A table-driven reference model
//               predicts every stage output and the illegal counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_maindec;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   pipe_maindec_if #(.CNT_W(8)) busA ();
   pipe_maindec_if #(.CNT_W(2)) busB ();

   pipe_maindec #(.EXT_OPS(1), .CNT_W(8)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA.slave)
   );

   pipe_maindec #(.EXT_OPS(0), .CNT_W(2)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Model state per instance (0 = A, 1 = B)
   // E word: {illegal, RegWrite, ImmSrc[2:0], ALUSrc, MemWrite, ResultSrc[1:0],
   //          Branch, ALUOp[1:0], Jump, Jalr}
   logic [13:0] mE [2];
   logic [3:0]  mM [2];   // {RegWrite, MemWrite, ResultSrc}
   logic [2:0]  mW [2];   // {RegWrite, ResultSrc}
   int          mCnt [2];

   // Straight transcription of the decode table
   function automatic logic [13:0] refDecode(input logic [6:0] op, input logic v, input int ext);
      if (!v) return 14'd0;
      case (op)
         7'b0000011: return {1'b0, 13'b1_000_1_0_01_0_00_0_0};
         7'b0100011: return {1'b0, 13'b0_001_1_1_00_0_00_0_0};
         7'b0110011: return {1'b0, 13'b1_000_0_0_00_0_10_0_0};
         7'b1100011: return {1'b0, 13'b0_010_0_0_00_1_01_0_0};
         7'b0010011: return {1'b0, 13'b1_000_1_0_00_0_10_0_0};
         7'b1101111: return {1'b0, 13'b1_011_0_0_10_0_00_1_0};
         7'b1100111: return (ext != 0) ? {1'b0, 13'b1_000_1_0_10_0_00_1_1} : {1'b1, 13'd0};
         7'b0110111: return (ext != 0) ? {1'b0, 13'b1_100_0_0_11_0_00_0_0} : {1'b1, 13'd0};
         default:    return {1'b1, 13'd0};
      endcase
   endfunction

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s inst=%0d observed=0x%0h expected=0x%0h", tag, k, obs, exp);
      end
   endtask

   task automatic checkInst(input int k, input logic [10:0] oE, input logic [3:0] oM,
                            input logic [2:0] oW, input int oCnt);
      logic [10:0] eE;
      eE = {mE[k][13], mE[k][12], mE[k][8], mE[k][7], mE[k][6:5],
            mE[k][4], mE[k][3:2], mE[k][1], mE[k][0]};
      check("E_stage", k, 32'(oE), 32'(eE));
      check("M_stage", k, 32'(oM), 32'(mM[k]));
      check("W_stage", k, 32'(oW), 32'(mW[k]));
      check("illegal_cnt", k, 32'(oCnt), 32'(mCnt[k]));
   endtask

   task automatic checkAll();
      checkInst(0,
         {busA.IllegalE, busA.RegWriteE, busA.ALUSrcE, busA.MemWriteE, busA.ResultSrcE,
          busA.BranchE, busA.ALUOpE, busA.JumpE, busA.JalrE},
         {busA.RegWriteM, busA.MemWriteM, busA.ResultSrcM},
         {busA.RegWriteW, busA.ResultSrcW},
         int'(busA.illegal_cnt));
      checkInst(1,
         {busB.IllegalE, busB.RegWriteE, busB.ALUSrcE, busB.MemWriteE, busB.ResultSrcE,
          busB.BranchE, busB.ALUOpE, busB.JumpE, busB.JalrE},
         {busB.RegWriteM, busB.MemWriteM, busB.ResultSrcM},
         {busB.RegWriteW, busB.ResultSrcW},
         int'(busB.illegal_cnt));
   endtask

   // One clock of stimulus: drive, check ImmSrcD, clock, advance model, check stages
   task automatic step(input logic [6:0] op, input logic v, input logic st,
                       input logic fl, input logic rs);
      logic [13:0] d;
      int          ext;
      int          cmax;
      busA.op_d = op; busA.valid_d = v; busA.stall_d = st; busA.flush_e = fl;
      busB.op_d = op; busB.valid_d = v; busB.stall_d = st; busB.flush_e = fl;
      reset = rs;
      #1;
      check("ImmSrcD", 0, 32'(busA.ImmSrcD), 32'(refDecode(op, v, 1) >> 9) & 32'h7);
      check("ImmSrcD", 1, 32'(busB.ImmSrcD), 32'(refDecode(op, v, 0) >> 9) & 32'h7);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         ext  = (k == 0) ? 1 : 0;
         cmax = (k == 0) ? 255 : 3;
         if (rs) begin
            mE[k] = '0; mM[k] = '0; mW[k] = '0; mCnt[k] = 0;
         end else begin
            mW[k] = {mM[k][3], mM[k][1:0]};
            mM[k] = {mE[k][12], mE[k][7], mE[k][6:5]};
            d     = refDecode(op, v, ext);
            mE[k] = (fl || st) ? 14'd0 : d;
            if (mE[k][13] && mCnt[k] < cmax) mCnt[k]++;
         end
      end
      #1;
      checkAll();
   endtask

   localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                          OP_R    = 7'b0110011, OP_BR    = 7'b1100011,
                          OP_I    = 7'b0010011, OP_JAL   = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111,
                          OP_BAD  = 7'b1111111;

   initial begin
      logic [6:0] opTab [9];
      logic [6:0] op;
      opTab[0] = OP_LOAD; opTab[1] = OP_STORE; opTab[2] = OP_R;
      opTab[3] = OP_BR;   opTab[4] = OP_I;     opTab[5] = OP_JAL;
      opTab[6] = OP_JALR; opTab[7] = OP_LUI;   opTab[8] = OP_BAD;
      for (int k = 0; k < 2; k++) begin
         mE[k] = '0; mM[k] = '0; mW[k] = '0; mCnt[k] = 0;
      end

      // Reset state
      step(OP_R, 1'b1, 1'b0, 1'b0, 1'b1);
      step(OP_R, 1'b1, 1'b0, 1'b0, 1'b1);

      // LOAD flowing through E, M, W
      step(OP_LOAD, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) step(7'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // STORE killed by flush
      step(OP_STORE, 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (2) step(7'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // LUI: legal on A, illegal on B
      step(OP_LUI, 1'b1, 1'b0, 1'b0, 1'b0);
      step(OP_JALR, 1'b1, 1'b0, 1'b0, 1'b0);
      step(7'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Five consecutive illegal opcodes: B saturates at 3
      repeat (5) step(OP_BAD, 1'b1, 1'b0, 1'b0, 1'b0);
      // Illegal opcode with valid_d low is not counted
      step(OP_BAD, 1'b0, 1'b0, 1'b0, 1'b0);

      // JAL then mid-stream reset
      step(OP_JAL, 1'b1, 1'b0, 1'b0, 1'b0);
      step(OP_I, 1'b1, 1'b0, 1'b0, 1'b1);
      step(OP_BR, 1'b1, 1'b0, 1'b0, 1'b0);

      // Stalled R-type, then resume; then stall+flush together
      repeat (3) step(OP_R, 1'b1, 1'b1, 1'b0, 1'b0);
      step(OP_R, 1'b1, 1'b0, 1'b0, 1'b0);
      step(OP_BAD, 1'b1, 1'b1, 1'b1, 1'b0);
      step(OP_I, 1'b1, 1'b0, 1'b0, 1'b0);

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) == 0) op = 7'($urandom);
         else                           op = opTab[$urandom_range(0, 8)];
         step(op,
              1'($urandom_range(0, 99) < 85),
              1'($urandom_range(0, 99) < 15),
              1'($urandom_range(0, 99) < 15),
              1'($urandom_range(0, 99) < 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
